posit_add_packer: RTL
=====================

# posit_add_packer

Request packer and issue scheduler for the shared SIMD posit adder alignment stage (`mant_align`). Accepts scalar add requests of one precision at a time. Packs them into the lane slots of a single vector bundle: 4 lanes at precision 00, 2 at 01, 1 at 10. Issues the bundle, with its lane-valid mask and per-lane tags, when it is full, when the precision changes, on timeout, or on an explicit flush.

## Interface
- `TAG_W`, default 4: per-request tag width, returned per lane for result steering.
- `TIMEOUT`, default 8: idle cycles (no accept) after which a partial bundle is issued; legal values are ≥1.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_pre` input 2: precision; 00 = 4 lanes, 01 = 2 lanes, 10 = 1 lane, 11 is treated as 00.
- `in_s_e`, `in_s_f`, `in_swap` input 1 each: operand signs and the swap flag.
- `in_exp_e`, `in_exp_f` input 20: exponents, right-justified.
- `in_mant_e`, `in_mant_f` input 56: mantissas, right-justified.
- `in_ctl` input 20: alignment shift amount, right-justified.
- `in_tag` input TAG_W: request tag.
- `flush` input 1: issue any partial bundle.
- `out_valid` output 1: bundle valid.
- `out_ready` input 1: datapath accepts the bundle.
- `out_pre` output 2: bundle precision.
- `out_s_e`, `out_s_f`, `out_swap` output 4 each: packed per-lane flags.
- `out_exp_e`, `out_exp_f` output 20: packed exponents.
- `out_mant_e`, `out_mant_f` output 56: packed mantissas.
- `out_ctl` output 20: packed shift amounts.
- `out_lane_vld` output 4: bit k is set when lane k is occupied.
- `out_tag` output 4*TAG_W: lane k tag at bits [k*TAG_W +: TAG_W].

## Operation
- States:
  - IDLE: no lanes occupied.
  - FILL: 1 or more lanes occupied, bundle not full.
  - ISSUE: bundle held on the outputs.
- `in_ready` = (state==IDLE) || (state==FILL && in_pre_norm==cur_pre). It is combinational and is low in ISSUE.
- Lane placement, lane k = fill count at the time of accept:
  - pre 00: exp/ctl bits [5k+4:5k], mant bits [14k+13:14k], flag bit k.
  - pre 01: exp/ctl bits [10k+9:10k], mant bits [28k+27:28k], flag bit 2k+1.
  - pre 10: all 20/56 bits, flag bit 3.
  - Input bits above the lane width are dropped.
  - Unoccupied lane fields and unused flag bits are driven 0.
- IDLE + accept:
  - Latch `cur_pre`, fill lane 0, clear the timeout counter.
  - Go to ISSUE if the lane count is 1, else to FILL.
- FILL:
  - Accept fills the next lane and clears the counter.
  - The fill that completes the lane count goes to ISSUE.
  - `in_valid` with a mismatched precision: the request is not accepted and the state goes to ISSUE.
  - `flush` goes to ISSUE. Accept and flush in the same cycle: the lane is filled first, then ISSUE.
  - A cycle with no accept increments the counter. When the counter reaches TIMEOUT-1 with no accept, go to ISSUE.
- IDLE + `flush`: no effect.
- ISSUE:
  - `out_valid`=1 and all outputs are stable until `out_valid && out_ready`.
  - On that handshake: clear lanes, mask, and counter, then go to IDLE.
- Reset mid-bundle discards all occupied lanes; no partial bundle is issued.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`=0; all out_* buses 0.
  - `out_pre`=00, `out_lane_vld`=0.
  - Counter 0.
  - `in_ready`=1 (from IDLE).
- Accept at cycle t that completes a bundle: `out_valid`=1 at t+1.
- Timeout: last accept at t, no further accepts → `out_valid` at t+TIMEOUT+1.
- No bypass from ISSUE to accept. A full 4-lane bundle takes at most 5 cycles when `out_ready` is held high.
- All state, lane registers, and outputs are registered except `in_ready`.

## Structure
- `posit_add_pkg` holds:
  - precision encodings PRE_4X=2'b00, PRE_2X=2'b01, PRE_1X=2'b10;
  - the lane-count function;
  - per-precision field widths (5/10/20 exp, 14/28/56 mant).
- One sub-module, `lane_insert`, is combinational. It writes one request into lane k of a bundle for a given precision and is instantiated once.

## Test plan
- pre 00, four back-to-back requests, tags 1..4, exp_e=5'h03 each, `out_ready`=1:
  - `out_valid` one cycle after the 4th accept.
  - `out_lane_vld`=4'hF, out_exp_e=20'h18C63.
  - `out_tag` = {4,3,2,1}.
- pre 10, single request, mant_e=56'hFF…F, swap=1:
  - `out_valid` the next cycle.
  - `out_swap`=4'b1000, `out_lane_vld`=4'b0001.
- pre 01: one request, then a pre 00 request:
  - The second request is stalled (`in_ready`=0).
  - The 2-lane bundle issues with mask 4'b0001.
  - The pre 00 request is accepted after the handshake.
- pre 00, two requests, then idle with TIMEOUT=8:
  - `out_valid` rises exactly 9 cycles after the 2nd accept.
  - `out_lane_vld`=4'b0011.
- Hold `out_ready`=0 for 10 cycles in ISSUE: outputs stable and `in_ready`=0. Assert `rst` during FILL: next cycle `out_valid`=0, `in_ready`=1, `out_lane_vld`=0.
- Accept and `flush` in the same cycle on the 3rd pre 00 request: bundle issues with `out_lane_vld`=4'b0111.

Source files
------------

// File: rtl/posit_add_pkg.sv
// Shared definitions for the posit adder request packer: precision
// encodings, per-precision lane field widths and the packer FSM states.
package posit_add_pkg;

  // Precision encodings; 2'b11 is folded onto PRE_4X by norm_pre().
  localparam logic [1:0] PRE_4X = 2'b00;
  localparam logic [1:0] PRE_2X = 2'b01;
  localparam logic [1:0] PRE_1X = 2'b10;

  // Full bundle widths.
  localparam int EXP_W  = 20;
  localparam int MANT_W = 56;
  localparam int LANES  = 4;

  // Per-lane field widths for each precision.
  localparam int EXP_W_4X  = 5;
  localparam int EXP_W_2X  = 10;
  localparam int EXP_W_1X  = 20;
  localparam int MANT_W_4X = 14;
  localparam int MANT_W_2X = 28;
  localparam int MANT_W_1X = 56;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE
  } state_e;

  // Number of lane slots a bundle of the given precision holds.
  function automatic logic [2:0] lane_count(input logic [1:0] pre);
    case (pre)
      PRE_2X:  return 3'd2;
      PRE_1X:  return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

  // The reserved encoding behaves exactly like the 4-lane precision.
  function automatic logic [1:0] norm_pre(input logic [1:0] pre);
    return (pre == 2'b11) ? PRE_4X : pre;
  endfunction

endpackage

// File: rtl/lane_insert.sv
// Combinational lane writer: merges one scalar request into lane `lane`
// of the current bundle for precision `pre`. Request bits above the lane
// width are dropped; every other bundle bit passes through unchanged.
module lane_insert
  import posit_add_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic [1:0]         pre,
  input  logic [1:0]         lane,
  input  logic               req_s_e,
  input  logic               req_s_f,
  input  logic               req_swap,
  input  logic [EXP_W-1:0]   req_exp_e,
  input  logic [EXP_W-1:0]   req_exp_f,
  input  logic [EXP_W-1:0]   req_ctl,
  input  logic [MANT_W-1:0]  req_mant_e,
  input  logic [MANT_W-1:0]  req_mant_f,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [3:0]         cur_s_e,
  input  logic [3:0]         cur_s_f,
  input  logic [3:0]         cur_swap,
  input  logic [3:0]         cur_lane_vld,
  input  logic [EXP_W-1:0]   cur_exp_e,
  input  logic [EXP_W-1:0]   cur_exp_f,
  input  logic [EXP_W-1:0]   cur_ctl,
  input  logic [MANT_W-1:0]  cur_mant_e,
  input  logic [MANT_W-1:0]  cur_mant_f,
  input  logic [4*TAG_W-1:0] cur_tag,
  output logic [3:0]         nxt_s_e,
  output logic [3:0]         nxt_s_f,
  output logic [3:0]         nxt_swap,
  output logic [3:0]         nxt_lane_vld,
  output logic [EXP_W-1:0]   nxt_exp_e,
  output logic [EXP_W-1:0]   nxt_exp_f,
  output logic [EXP_W-1:0]   nxt_ctl,
  output logic [MANT_W-1:0]  nxt_mant_e,
  output logic [MANT_W-1:0]  nxt_mant_f,
  output logic [4*TAG_W-1:0] nxt_tag
);

  // Overlay the request onto the selected lane slot.
  always_comb begin
    // NOTE: every output gets a full default before the case so no path leaves it unassigned (no latch).
    nxt_s_e      = cur_s_e;
    nxt_s_f      = cur_s_f;
    nxt_swap     = cur_swap;
    nxt_lane_vld = cur_lane_vld;
    nxt_exp_e    = cur_exp_e;
    nxt_exp_f    = cur_exp_f;
    nxt_ctl      = cur_ctl;
    nxt_mant_e   = cur_mant_e;
    nxt_mant_f   = cur_mant_f;
    nxt_tag      = cur_tag;

    nxt_lane_vld[lane]             = 1'b1;
    nxt_tag[lane*TAG_W +: TAG_W]   = req_tag;

    case (pre)
      PRE_2X: begin
        nxt_exp_e[lane[0]*EXP_W_2X +: EXP_W_2X]   = req_exp_e[EXP_W_2X-1:0];
        nxt_exp_f[lane[0]*EXP_W_2X +: EXP_W_2X]   = req_exp_f[EXP_W_2X-1:0];
        nxt_ctl[lane[0]*EXP_W_2X +: EXP_W_2X]     = req_ctl[EXP_W_2X-1:0];
        nxt_mant_e[lane[0]*MANT_W_2X +: MANT_W_2X] = req_mant_e[MANT_W_2X-1:0];
        nxt_mant_f[lane[0]*MANT_W_2X +: MANT_W_2X] = req_mant_f[MANT_W_2X-1:0];
        // A 2-lane bundle reports its flags in the odd bit positions.
        nxt_s_e[{lane[0], 1'b1}]  = req_s_e;
        nxt_s_f[{lane[0], 1'b1}]  = req_s_f;
        nxt_swap[{lane[0], 1'b1}] = req_swap;
      end
      PRE_1X: begin
        nxt_exp_e   = req_exp_e[EXP_W_1X-1:0];
        nxt_exp_f   = req_exp_f[EXP_W_1X-1:0];
        nxt_ctl     = req_ctl[EXP_W_1X-1:0];
        nxt_mant_e  = req_mant_e[MANT_W_1X-1:0];
        nxt_mant_f  = req_mant_f[MANT_W_1X-1:0];
        nxt_s_e[3]  = req_s_e;
        nxt_s_f[3]  = req_s_f;
        nxt_swap[3] = req_swap;
      end
      default: begin
        nxt_exp_e[lane*EXP_W_4X +: EXP_W_4X]    = req_exp_e[EXP_W_4X-1:0];
        nxt_exp_f[lane*EXP_W_4X +: EXP_W_4X]    = req_exp_f[EXP_W_4X-1:0];
        nxt_ctl[lane*EXP_W_4X +: EXP_W_4X]      = req_ctl[EXP_W_4X-1:0];
        nxt_mant_e[lane*MANT_W_4X +: MANT_W_4X] = req_mant_e[MANT_W_4X-1:0];
        nxt_mant_f[lane*MANT_W_4X +: MANT_W_4X] = req_mant_f[MANT_W_4X-1:0];
        nxt_s_e[lane]  = req_s_e;
        nxt_s_f[lane]  = req_s_f;
        nxt_swap[lane] = req_swap;
      end
    endcase
  end

endmodule

// File: rtl/posit_add_packer.sv
// Request packer for the shared SIMD posit adder alignment stage. Collects
// same-precision scalar requests into one vector bundle and issues it when
// full, on a precision change, on idle timeout or on flush.
module posit_add_packer
  import posit_add_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_pre,
  input  logic               in_s_e,
  input  logic               in_s_f,
  input  logic               in_swap,
  input  logic [EXP_W-1:0]   in_exp_e,
  input  logic [EXP_W-1:0]   in_exp_f,
  input  logic [MANT_W-1:0]  in_mant_e,
  input  logic [MANT_W-1:0]  in_mant_f,
  input  logic [EXP_W-1:0]   in_ctl,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_pre,
  output logic [3:0]         out_s_e,
  output logic [3:0]         out_s_f,
  output logic [3:0]         out_swap,
  output logic [EXP_W-1:0]   out_exp_e,
  output logic [EXP_W-1:0]   out_exp_f,
  output logic [MANT_W-1:0]  out_mant_e,
  output logic [MANT_W-1:0]  out_mant_f,
  output logic [EXP_W-1:0]   out_ctl,
  output logic [3:0]         out_lane_vld,
  output logic [4*TAG_W-1:0] out_tag
);

  // Idle counter only has to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state;
  logic [2:0]        fill_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pre_norm;
  logic              accept;

  logic [3:0]         nxt_s_e;
  logic [3:0]         nxt_s_f;
  logic [3:0]         nxt_swap;
  logic [3:0]         nxt_lane_vld;
  logic [EXP_W-1:0]   nxt_exp_e;
  logic [EXP_W-1:0]   nxt_exp_f;
  logic [EXP_W-1:0]   nxt_ctl;
  logic [MANT_W-1:0]  nxt_mant_e;
  logic [MANT_W-1:0]  nxt_mant_f;
  logic [4*TAG_W-1:0] nxt_tag;

  assign pre_norm = norm_pre(in_pre);
  // out_pre doubles as the precision of the bundle being filled.
  assign in_ready = (state == S_IDLE) || ((state == S_FILL) && (pre_norm == out_pre));
  assign accept   = in_valid && in_ready;

  // An accept implies pre_norm matches the bundle, so it selects the lane layout.
  lane_insert #(
    .TAG_W (TAG_W)
  ) u_lane_insert (
    .pre          (pre_norm),
    .lane         (fill_cnt[1:0]),
    .req_s_e      (in_s_e),
    .req_s_f      (in_s_f),
    .req_swap     (in_swap),
    .req_exp_e    (in_exp_e),
    .req_exp_f    (in_exp_f),
    .req_ctl      (in_ctl),
    .req_mant_e   (in_mant_e),
    .req_mant_f   (in_mant_f),
    .req_tag      (in_tag),
    .cur_s_e      (out_s_e),
    .cur_s_f      (out_s_f),
    .cur_swap     (out_swap),
    .cur_lane_vld (out_lane_vld),
    .cur_exp_e    (out_exp_e),
    .cur_exp_f    (out_exp_f),
    .cur_ctl      (out_ctl),
    .cur_mant_e   (out_mant_e),
    .cur_mant_f   (out_mant_f),
    .cur_tag      (out_tag),
    .nxt_s_e      (nxt_s_e),
    .nxt_s_f      (nxt_s_f),
    .nxt_swap     (nxt_swap),
    .nxt_lane_vld (nxt_lane_vld),
    .nxt_exp_e    (nxt_exp_e),
    .nxt_exp_f    (nxt_exp_f),
    .nxt_ctl      (nxt_ctl),
    .nxt_mant_e   (nxt_mant_e),
    .nxt_mant_f   (nxt_mant_f),
    .nxt_tag      (nxt_tag)
  );

  // Packer FSM: lane registers, idle counter and registered bundle outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset clears every lane register, so an interrupted bundle is discarded, never issued.
      state        <= S_IDLE;
      fill_cnt     <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_pre      <= PRE_4X;
      out_s_e      <= '0;
      out_s_f      <= '0;
      out_swap     <= '0;
      out_exp_e    <= '0;
      out_exp_f    <= '0;
      out_mant_e   <= '0;
      out_mant_f   <= '0;
      out_ctl      <= '0;
      out_lane_vld <= '0;
      out_tag      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      if (accept) begin
        out_s_e      <= nxt_s_e;
        out_s_f      <= nxt_s_f;
        out_swap     <= nxt_swap;
        out_exp_e    <= nxt_exp_e;
        out_exp_f    <= nxt_exp_f;
        out_mant_e   <= nxt_mant_e;
        out_mant_f   <= nxt_mant_f;
        out_ctl      <= nxt_ctl;
        out_lane_vld <= nxt_lane_vld;
        out_tag      <= nxt_tag;
        fill_cnt     <= fill_cnt + 3'd1;
        cnt          <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            out_pre <= pre_norm;
            if (lane_count(pre_norm) == 3'd1) begin
              state     <= S_ISSUE;
              out_valid <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (accept) begin
            // The lane is written above; flush alongside it still issues.
            if ((fill_cnt + 3'd1 == lane_count(out_pre)) || flush) begin
              state     <= S_ISSUE;
              out_valid <= 1'b1;
            end
          end else if (in_valid || flush || (cnt == CNT_LAST)) begin
            // in_valid without accept means a precision change.
            state     <= S_ISSUE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            fill_cnt     <= '0;
            cnt          <= '0;
            out_pre      <= PRE_4X;
            out_s_e      <= '0;
            out_s_f      <= '0;
            out_swap     <= '0;
            out_exp_e    <= '0;
            out_exp_f    <= '0;
            out_mant_e   <= '0;
            out_mant_f   <= '0;
            out_ctl      <= '0;
            out_lane_vld <= '0;
            out_tag      <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
